// File: rtl/imem_loader.sv
// imem_loader: streams a big-endian byte image into memory as 32-bit words
// through the memory's ordinary write port, holding fetch (stall) until the
// whole image has been written.
module imem_loader #(
    parameter logic [31:0] base_addr = 32'h8002_0000,
    parameter int unsigned max_words = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] num_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [31:0] address,
    output logic [31:0] data_in,
    output logic [1:0]  access_size,
    output logic        rw,
    output logic        mem_enable,
    input  logic        busy,
    output logic        stall,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] count_q;     // latched image length in words
    logic [15:0] index_q;     // word index of the word being assembled/written
    logic [1:0]  byte_cnt_q;  // byte position k within the current word
    logic [31:0] word_q;      // word buffer, first byte in [31:24]

    logic        start_ok;
    logic        too_big;
    logic        load_go;
    logic        byte_take;
    logic        last_word;
    logic [4:0]  lane_lsb;

    // start is honoured only while no load is in flight
    assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    assign too_big   = 32'(num_words) > max_words;
    assign load_go   = start_ok && (num_words != 16'd0) && !too_big;
    // byte_ready is decoded from state only, so this AND is the handshake
    assign byte_take = (state_q == S_COLLECT) && byte_valid;
    assign last_word = (index_q + 16'd1) == count_q;
    // lane 3-k: inverting the 2-bit counter gives 3-k directly
    assign lane_lsb  = {~byte_cnt_q, 3'b000};

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_ok) begin
                    if (num_words == 16'd0) begin
                        state_d = S_DONE;
                    end else if (too_big) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (byte_take && (byte_cnt_q == 2'd3)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!busy) begin
                    state_d = last_word ? S_DONE : S_COLLECT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: image length, word index, byte counter and word packing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= 16'd0;
            index_q    <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
        end else begin
            if (load_go) begin
                count_q    <= num_words;
                index_q    <= 16'd0;
                byte_cnt_q <= 2'd0;
            end
            if (byte_take) begin
                word_q[lane_lsb +: 8] <= byte_data;
                byte_cnt_q            <= byte_cnt_q + 2'd1;
            end
            if ((state_q == S_WAIT) && !busy) begin
                index_q <= index_q + 16'd1;
            end
        end
    end

    // Address follows the registered index, so it is stable through WAIT
    assign address     = base_addr + {14'd0, index_q, 2'b00};
    assign data_in     = word_q;
    assign access_size = 2'b00;

    // Output decode from the registered state
    always_comb begin
        byte_ready = 1'b0;
        mem_enable = 1'b0;
        rw         = 1'b1;
        stall      = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state_q)
            S_COLLECT: byte_ready = 1'b1;
            S_WRITE: begin
                mem_enable = 1'b1;
                rw         = 1'b0;
            end
            S_DONE: begin
                done  = 1'b1;
                stall = 1'b0;
            end
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed loads with a write scoreboard. The
// stimulus pushes the expected (address, data) pairs; a monitor pops and
// compares them whenever the loader strobes a memory write.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h8002_0000;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [15:0] num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [1:0]  access_size;
    logic        rw;
    logic        mem_enable;
    logic        busy = 1'b0;
    logic        stall;
    logic        done;
    logic        error;

    imem_loader #(
        .base_addr(BASE),
        .max_words(256)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .address    (address),
        .data_in    (data_in),
        .access_size(access_size),
        .rw         (rw),
        .mem_enable (mem_enable),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         last_exp;
    logic [7:0]  stim[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          busy_hold = 0;
    int          write_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every write strobe must match the head of the scoreboard;
    // while busy holds WAIT, the bus must still show the last written word.
    always @(negedge clock) begin
        if (reset_n && mem_enable) begin
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                last_exp = exp_q.pop_front();
                check("write_addr", address, last_exp.addr);
                check("write_data", data_in, last_exp.data);
                check("write_rw", 32'(rw), 32'd0);
                check("write_size", 32'(access_size), 32'd0);
            end
            write_seen++;
        end else if (reset_n && busy) begin
            check("hold_addr", address, last_exp.addr);
            check("hold_data", data_in, last_exp.data);
        end
    end

    // Memory model busy: high for busy_hold cycles after each write strobe
    always @(posedge clock) begin
        int handled;
        int left;
        #1;
        if (left > 0) left--;
        if (write_seen != handled) begin
            handled = write_seen;
            left    = busy_hold;
        end
        busy = (left > 0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n, output int unsigned s);
        start     = 1'b1;
        num_words = n;
        tick();
        s     = cyc;
        start = 1'b0;
    endtask

    // Offer stim[] bytes; a byte advances only when the loader accepted it.
    // A one-cycle start pulse is injected at iteration glitch_at (if >= 0).
    task automatic send_bytes(input bit toggle, input int glitch_at);
        int idx   = 0;
        int guard = 0;
        bit phase = 1'b0;
        bit acc;
        while (idx < stim.size() && guard < 500) begin
            byte_valid = toggle ? phase : 1'b1;
            phase      = ~phase;
            byte_data  = stim[idx];
            start      = (guard == glitch_at);
            if (guard == glitch_at) num_words = 16'd5;
            @(negedge clock);
            acc = byte_valid && byte_ready;
            tick();
            if (acc) idx++;
            guard++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        check("stream_consumed", 32'(idx), 32'(stim.size()));
    endtask

    // Wait for done; optionally check its cycle relative to the start edge
    task automatic wait_done(input int unsigned s, input int exp_delta);
        int   guard = 0;
        logic prev_stall;
        prev_stall = stall;
        @(negedge clock);
        while (!done && guard < 300) begin
            prev_stall = stall;
            @(negedge clock);
            guard++;
        end
        check("done_seen", 32'(done), 32'd1);
        if (exp_delta >= 0) check("done_cycle", cyc - s, 32'(exp_delta));
        check("stall_before_done", 32'(prev_stall), 32'd1);
        check("stall_after_done", 32'(stall), 32'd0);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic check_reset_values();
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_enable", 32'(mem_enable), 32'd0);
        check("rst_rw", 32'(rw), 32'd1);
        check("rst_access_size", 32'(access_size), 32'd0);
        check("rst_address", address, BASE);
        check("rst_data_in", data_in, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s;

        reset_n    = 1'b0;
        start      = 1'b0;
        num_words  = 16'd0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #2;
        check_reset_values();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_byte_ready", 32'(byte_ready), 32'd0);

        // Two words, continuous stream, memory never busy
        busy_hold = 0;
        push_exp(BASE,          32'h8CA3_0000);
        push_exp(BASE + 32'd4,  32'h2402_0005);
        stim = '{8'h8C, 8'hA3, 8'h00, 8'h00, 8'h24, 8'h02, 8'h00, 8'h05};
        do_start(16'd2, s);
        send_bytes(1'b0, -1);
        wait_done(s, 12);

        // Same image with busy high for 3 cycles after each write
        busy_hold = 3;
        push_exp(BASE,          32'h8CA3_0000);
        push_exp(BASE + 32'd4,  32'h2402_0005);
        do_start(16'd2, s);
        send_bytes(1'b0, -1);
        wait_done(s, 18);
        busy_hold = 0;

        // Gapped stream with a start pulse during COLLECT
        push_exp(BASE,          32'h1122_3344);
        push_exp(BASE + 32'd4,  32'h5566_7788);
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_start(16'd2, s);
        send_bytes(1'b1, 2);
        wait_done(s, -1);

        // Oversized image: ERROR, no bytes taken, no writes
        do_start(16'd257, s);
        check("err_error", 32'(error), 32'd1);
        check("err_stall", 32'(stall), 32'd1);
        check("err_done", 32'(done), 32'd0);
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_byte_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;

        // Empty image from ERROR: DONE on the very next cycle
        do_start(16'd0, s);
        check("zero_done", 32'(done), 32'd1);
        check("zero_error", 32'(error), 32'd0);
        check("zero_stall", 32'(stall), 32'd0);
        tick();

        // Largest legal image is accepted (load aborted by reset)
        do_start(16'd256, s);
        check("max_error", 32'(error), 32'd0);
        check("max_byte_ready", 32'(byte_ready), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Reset after 6 bytes of a 3-word load: only word 0 is written
        push_exp(BASE, 32'hA1B2_C3D4);
        stim = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        do_start(16'd3, s);
        send_bytes(1'b0, -1);
        reset_n = 1'b0;
        #1;
        check_reset_values();
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        push_exp(BASE, 32'h0BAD_F00D);
        stim = '{8'h0B, 8'hAD, 8'hF0, 8'h0D};
        do_start(16'd1, s);
        send_bytes(1'b0, -1);
        wait_done(s, 6);

        // Back-to-back: restart from DONE
        push_exp(BASE, 32'h1357_9BDF);
        stim = '{8'h13, 8'h57, 8'h9B, 8'hDF};
        do_start(16'd1, s);
        check("restart_stall", 32'(stall), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        send_bytes(1'b0, -1);
        wait_done(s, 6);

        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
